// File: rtl/pipeline_hazard_sched.sv
// pipeline_hazard_sched: stall/flush/freeze scheduler for the 5-stage pipeline.
// Resolves load-use stalls, taken-branch and jump flushes, and freezes the
// whole pipeline while a multi-cycle data-memory access completes.
// The enable/flush/ack outputs are combinational from the state and the
// current inputs; the FSM, the wait counter and the perf counters are
// registered.
// Optional feature: define HAZ_PERF_CNT_EN to build the saturating
// stall/flush/freeze counters. Without it those ports read 0.
//
// state | meaning
// RUN   | normal flow; an access request with MEM_LATENCY>1 freezes
// WAIT  | memory still busy, pipeline frozen, wcnt counts down
// GO    | access completes (mem_ack), pipeline advances, mem_req ignored

module pipeline_hazard_sched #(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_dest,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_ack,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_GO   = 2'd2
    } state_t;

    // Single-cycle RAM never leaves RUN; LAT==2 goes straight to GO.
    localparam bit         MULTI     = (MEM_LATENCY > 1);
    localparam bit         SHORT     = (MEM_LATENCY == 2);
    localparam logic [3:0] WAIT_INIT = (MEM_LATENCY > 2) ? 4'(MEM_LATENCY - 3) : 4'd0;

    state_t     state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;

    logic freeze;
    logic load_use;
    logic br_evt;
    logic lu_evt;
    logic jmp_evt;

    // Next-state and wait-counter logic for the memory access sequencer.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_req && MULTI) begin
                    state_d = SHORT ? ST_GO : ST_WAIT;
                    wcnt_d  = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = ST_GO;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_GO:   state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // FSM state and wait counter; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Hazard detection; branch beats load-use beats jump, none act while frozen.
    always_comb begin
        freeze   = ((state_q == ST_RUN) && mem_req && MULTI) || (state_q == ST_WAIT);
        load_use = ex_mem_read && (ex_dest != 5'd0) &&
                   ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));
        br_evt   = !freeze && ex_branch_taken;
        lu_evt   = !freeze && !ex_branch_taken && load_use;
        jmp_evt  = !freeze && !ex_branch_taken && !load_use && id_jump;
    end

    // Pipeline control outputs; held at the idle pattern while reset is low.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        mem_ack     = 1'b0;
        if (reset) begin
            mem_ack = (state_q == ST_GO) || (!MULTI && (state_q == ST_RUN) && mem_req);
            if (freeze) begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
            end else if (br_evt) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (lu_evt) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (jmp_evt) begin
                if_id_flush = 1'b1;
            end
        end
    end

    assign state_o = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

    // Saturating event counters; they stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        if (lu_evt && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((br_evt || jmp_evt) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (freeze && (freeze_cnt_q != '1)) begin
            freeze_cnt_d = freeze_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
`else
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign freeze_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_sched.sv
// Directed bench for pipeline_hazard_sched: one instance with a 4-cycle
// memory and one with single-cycle memory, both driven by the same inputs.
module tb_pipeline_hazard_sched;

`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_dest;
    logic       id_uses_rt, id_jump, ex_mem_read, ex_branch_taken, mem_req;

    logic        pc_en4, if_id_en4, if_id_flush4, id_ex_en4, id_ex_flush4, ex_mem_en4, mem_wb_en4, mem_ack4;
    logic [1:0]  state4;
    logic [31:0] stall4, flush4, freeze4;
    logic        pc_en1, if_id_en1, if_id_flush1, id_ex_en1, id_ex_flush1, ex_mem_en1, mem_wb_en1, mem_ack1;
    logic [1:0]  state1;
    logic [31:0] stall1, flush1, freeze1;

    int n_chk = 0;
    int n_err = 0;

    pipeline_hazard_sched #(.MEM_LATENCY(4), .CNT_W(32)) u_dut4 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
        .pc_en(pc_en4), .if_id_en(if_id_en4), .if_id_flush(if_id_flush4), .id_ex_en(id_ex_en4),
        .id_ex_flush(id_ex_flush4), .ex_mem_en(ex_mem_en4), .mem_wb_en(mem_wb_en4),
        .mem_ack(mem_ack4), .state_o(state4), .stall_cnt(stall4), .flush_cnt(flush4),
        .freeze_cnt(freeze4)
    );

    pipeline_hazard_sched #(.MEM_LATENCY(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
        .pc_en(pc_en1), .if_id_en(if_id_en1), .if_id_flush(if_id_flush1), .id_ex_en(id_ex_en1),
        .id_ex_flush(id_ex_flush1), .ex_mem_en(ex_mem_en1), .mem_wb_en(mem_wb_en1),
        .mem_ack(mem_ack1), .state_o(state1), .stall_cnt(stall1), .flush_cnt(flush1),
        .freeze_cnt(freeze1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_jump = 1'b0;
        ex_mem_read = 1'b0; ex_dest = 5'd0; ex_branch_taken = 1'b0; mem_req = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        clr_in();
        #2;
        // reset values
        chk("rst_state", 32'(state4), 32'd0);
        chk("rst_pc_en", 32'(pc_en4), 32'd1);
        chk("rst_flush", 32'({if_id_flush4, id_ex_flush4}), 32'd0);
        chk("rst_mem_ack", 32'(mem_ack4), 32'd0);
        chk("rst_cnt", stall4 | flush4 | freeze4, 32'd0);
        step();
        reset = 1'b1;

        // A: lw $t0 in EX, ID reads $t0 through rs
        ex_mem_read = 1'b1; ex_dest = 5'd8; id_rs = 5'd8;
        #1;
        chk("lu_rs_ctl", 32'({pc_en4, if_id_en4, id_ex_flush4, if_id_flush4, ex_mem_en4, mem_wb_en4}), 32'b001011);
        step();

        // B: match only on rt but rt unused -> no stall
        id_rs = 5'd9; id_rt = 5'd8; id_uses_rt = 1'b0;
        #1;
        chk("lu_rt_unused", 32'({pc_en4, if_id_en4, id_ex_flush4}), 32'b110);
        chk("stall_after_a", stall4, PERF ? 32'd1 : 32'd0);
        step();

        // C: rt used -> stall
        id_uses_rt = 1'b1;
        #1;
        chk("lu_rt_ctl", 32'({pc_en4, if_id_en4, id_ex_flush4}), 32'b001);
        step();

        // D: branch taken with load-use also true
        ex_branch_taken = 1'b1;
        #1;
        chk("br_lu_ctl", 32'({pc_en4, if_id_flush4, id_ex_flush4}), 32'b111);
        chk("stall_after_c", stall4, PERF ? 32'd2 : 32'd0);
        step();

        // E: $zero destination never hazards; jump flushes IF/ID only
        ex_branch_taken = 1'b0; ex_dest = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_jump = 1'b1;
        #1;
        chk("zero_jmp_ctl", 32'({pc_en4, if_id_en4, if_id_flush4, id_ex_flush4, id_ex_en4}), 32'b11101);
        chk("flush_after_d", flush4, PERF ? 32'd1 : 32'd0);
        chk("stall_after_d", stall4, PERF ? 32'd2 : 32'd0);
        step();

        // F: jump with load-use -> stall wins
        ex_dest = 5'd8; id_rs = 5'd8;
        #1;
        chk("jmp_lu_ctl", 32'({pc_en4, if_id_en4, if_id_flush4, id_ex_flush4}), 32'b0001);
        step();

        clr_in();
        #1;
        chk("hz_stall4", stall4, PERF ? 32'd3 : 32'd0);
        chk("hz_flush4", flush4, PERF ? 32'd2 : 32'd0);
        chk("hz_stall1", stall1, PERF ? 32'd3 : 32'd0);

        // Memory access: RUN(freeze), WAIT, WAIT, GO; taken branch ignored while frozen
        mem_req = 1'b1; ex_branch_taken = 1'b1;
        #1;
        chk("m0_ctl4", 32'({state4, pc_en4, if_id_en4, ex_mem_en4, mem_wb_en4, mem_ack4, if_id_flush4}), 32'd0);
        chk("m0_ctl1", 32'({state1, pc_en1, mem_ack1, if_id_flush1}), 32'b00111);
        step();
        ex_branch_taken = 1'b0;
        #1;
        chk("m1_state", 32'(state4), 32'd1);
        chk("m1_ack", 32'(mem_ack4), 32'd0);
        step();
        chk("m2_ctl", 32'({state4, ex_mem_en4, id_ex_en4}), 32'b0100);
        step();
        chk("go_ctl", 32'({state4, mem_ack4, pc_en4, mem_wb_en4}), 32'b10111);
        chk("go_state1", 32'({state1, mem_ack1}), 32'b001);
        mem_req = 1'b0;
        step();
        chk("back_run", 32'({state4, mem_ack4, pc_en4}), 32'b0001);
        chk("freeze_cnt4", freeze4, PERF ? 32'd3 : 32'd0);
        chk("flush_cnt4", flush4, PERF ? 32'd2 : 32'd0);
        chk("flush_cnt1", flush1, PERF ? 32'd3 : 32'd0);
        chk("freeze_cnt1", freeze1, 32'd0);

        // Reset asserted mid-WAIT with the request still held
        mem_req = 1'b1;
        step();
        chk("pre_rst_wait", 32'(state4), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_ctl", 32'({state4, pc_en4, if_id_en4, ex_mem_en4, mem_ack4}), 32'b001110);
        chk("mid_rst_cnt", stall4 | flush4 | freeze4, 32'd0);
        step();
        chk("rst_hold_ack", 32'({mem_ack4, mem_ack1}), 32'd0);
        mem_req = 1'b0;
        reset = 1'b1;
        step();
        chk("post_rst", 32'({state4, mem_ack4, pc_en4}), 32'b0001);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
